// File: rtl/byte_serial_adder_pkg.sv
// rtl/byte_serial_adder_pkg.sv - shared widths and FSM state type for the byte-serial adder
package byte_serial_adder_pkg;

  localparam int BYTE_W = 8;
  localparam int NBYTES = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_8bit.sv
// rtl/full_adder_8bit.sv - combinational 8-bit adder slice with carry in/out
module full_adder_8bit
  import byte_serial_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic [BYTE_W:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, ci};
  end

  assign s  = total[BYTE_W-1:0];
  assign co = total[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - 32-bit add/subtract computed one byte per cycle over a shared 8-bit adder
module byte_serial_adder
  import byte_serial_adder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              overflow
);

  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  state_t            state;
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;
  logic [WORD_W-1:0] work;
  logic [WORD_W-1:0] work_next;
  logic              carry;
  logic [1:0]        idx;
  logic [BYTE_W-1:0] fa_a;
  logic [BYTE_W-1:0] fa_b;
  logic [BYTE_W-1:0] fa_s;
  logic              fa_co;

  // The single adder slice is steered to the current byte lane by idx.
  always_comb begin
    fa_a = a_q[{idx, 3'b000} +: BYTE_W];
    fa_b = b_q[{idx, 3'b000} +: BYTE_W];
    work_next = work;
    work_next[{idx, 3'b000} +: BYTE_W] = fa_s;
  end

  full_adder_8bit u_fa (
    .a  (fa_a),
    .b  (fa_b),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so the operand and carry are prepared here.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= 2'd0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= fa_co;
          idx   <= idx + 2'd1;
          if (idx == LAST_IDX) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= work_next;
            cout     <= fa_co;
            overflow <= (a_q[WORD_W-1] == b_q[WORD_W-1]) &&
                        (work_next[WORD_W-1] != a_q[WORD_W-1]);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder.sv
// tb/tb_byte_serial_adder.sv - directed self-checking bench for byte_serial_adder
module tb_byte_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;

  int vectors = 0;
  int misses  = 0;

  byte_serial_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vcin, input logic vsub);
    a   = va;
    b   = vb;
    cin = vcin;
    sub = vsub;
  endtask

  // Waits from the accept edge to the done cycle; returns cycles counted at negedges.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vcin, input logic vsub, input logic [31:0] esum,
                        input logic ecout, input logic eov);
    int cyc;
    @(negedge clk);
    drive(va, vb, vcin, vsub);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drive(32'hDEAD_BEEF, 32'h1234_5678, ~vcin, ~vsub);
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    wait_done(cyc);
    check({tag, ".lat"}, cyc, 32'd5);
    check({tag, ".sum"}, sum, esum);
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, ecout});
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eov});
    @(negedge clk);
    check({tag, ".done1"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    logic [31:0] xa [3];
    logic [31:0] xb [3];
    logic        xs [3];
    logic [31:0] xr [3];
    logic        xc [3];
    logic        xv [3];

    rst_n = 1'b0;
    start = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.sum", sum, 32'd0);
    check("rst.cout", {31'd0, cout}, 32'd0);
    check("rst.ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("add_sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_5_7",  32'd5,         32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_7_5",  32'd7,         32'd5,         1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_op("add_cin",  32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    run_op("sub_sovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    start = 1'b1;
    check("ign.hold", sum, 32'h7FFF_FFFF);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        check("ign.sum", sum, 32'h2345_6789);
      end
      @(negedge clk);
    end
    check("ign.ndone", ndone, 32'd1);

    // Reset in the middle of RUN aborts the operation.
    drive(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.sum", sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort.nodone", ndone, 32'd0);
    run_op("post_rst", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);

    // Start held high: each accept latches fresh operands.
    xa[0] = 32'h0102_0304; xb[0] = 32'h1020_3040; xs[0] = 1'b0;
    xr[0] = 32'h1122_3344; xc[0] = 1'b0; xv[0] = 1'b0;
    xa[1] = 32'h0000_0010; xb[1] = 32'h0000_0020; xs[1] = 1'b1;
    xr[1] = 32'hFFFF_FFF0; xc[1] = 1'b0; xv[1] = 1'b0;
    xa[2] = 32'h8000_0000; xb[2] = 32'h8000_0000; xs[2] = 1'b0;
    xr[2] = 32'h0000_0000; xc[2] = 1'b1; xv[2] = 1'b1;
    @(negedge clk);
    drive(xa[0], xb[0], 1'b0, xs[0]);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 2) drive(xa[k+1], xb[k+1], 1'b0, xs[k+1]);
      else start = 1'b0;
      wait_done(cyc);
      check($sformatf("b2b%0d.lat", k), cyc, 32'd5);
      check($sformatf("b2b%0d.sum", k), sum, xr[k]);
      check($sformatf("b2b%0d.cout", k), {31'd0, cout}, {31'd0, xc[k]});
      check($sformatf("b2b%0d.ovf", k), {31'd0, overflow}, {31'd0, xv[k]});
    end
    @(negedge clk);
    check("b2b.idle", {30'd0, busy, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
